// File: rtl/pmp_fault_ctrl_pkg.sv
// Shared definitions for the PMP fault controller: request mode encodings,
// mcause access-fault codes, the controller state type and a mode-to-cause
// helper used when a fault is captured.
package pmp_fault_ctrl_pkg;

  // Request mode encodings carried alongside each checked request
  localparam logic [1:0] PMP_MODE_NONE  = 2'b00;
  localparam logic [1:0] PMP_MODE_LOAD  = 2'b01;
  localparam logic [1:0] PMP_MODE_STORE = 2'b10;
  localparam logic [1:0] PMP_MODE_FETCH = 2'b11;

  // mcause codes for the three access-fault flavours
  localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] EXC_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] EXC_STORE_ACCESS_FAULT = 4'd7;

  // Controller states: idle, exception offered to the trap unit, and
  // exception accepted but the pipeline not yet flushed
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PEND       = 2'd1,
    WAIT_FLUSH = 2'd2
  } pmp_fault_state_e;

  // Maps a request mode to its access-fault cause; NONE never faults, so
  // it maps to zero purely as a safe default
  function automatic logic [3:0] modeToCause(input logic [1:0] mode);
    logic [3:0] cause;
    case (mode)
      PMP_MODE_FETCH: cause = EXC_INSTR_ACCESS_FAULT;
      PMP_MODE_LOAD:  cause = EXC_LOAD_ACCESS_FAULT;
      PMP_MODE_STORE: cause = EXC_STORE_ACCESS_FAULT;
      default:        cause = 4'd0;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/pmp_fault_ctrl_pick.sv
// pmp_fault_pick: combinational lowest-index priority picker. Given the
// per-channel fault vector it reports whether any channel faulted, which
// one wins (index 0 highest priority), and that channel's cause and address.
module pmp_fault_pick
  import pmp_fault_ctrl_pkg::*;
#(
  parameter int REQ_CHANNEL_NUM = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int IDX_W           = (REQ_CHANNEL_NUM > 1) ? $clog2(REQ_CHANNEL_NUM) : 1
) (
  input  logic [REQ_CHANNEL_NUM-1:0]            fault_i,
  input  logic [REQ_CHANNEL_NUM*ADDR_WIDTH-1:0] addr_i,
  input  logic [REQ_CHANNEL_NUM*2-1:0]          mode_i,
  output logic                                  hit_o,
  output logic [IDX_W-1:0]                      idx_o,
  output logic [3:0]                            cause_o,
  output logic [ADDR_WIDTH-1:0]                 addr_o
);

  // Scan from the highest index down so the lowest faulting index is the
  // last assignment and therefore wins
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    cause_o = '0;
    addr_o  = '0;
    for (int i = REQ_CHANNEL_NUM - 1; i >= 0; i--) begin
      if (fault_i[i]) begin
        hit_o   = 1'b1;
        idx_o   = IDX_W'(i);
        cause_o = modeToCause(mode_i[2*i +: 2]);
        addr_o  = addr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pmp_fault_ctrl.sv
// pmp_fault_ctrl: sits behind the PMP checker, kills failing accesses,
// captures the highest-priority fault and offers it to the trap unit as an
// access-fault exception over a valid/ready handshake. All accesses stay
// killed from capture until the trap unit flushes the pipeline.
// Optional build macro PMP_FAULT_CNT_EN adds saturating per-class fault
// counters on fault_cnt; without it fault_cnt is tied to zero.
module pmp_fault_ctrl
  import pmp_fault_ctrl_pkg::*;
#(
  parameter int REQ_CHANNEL_NUM = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [REQ_CHANNEL_NUM-1:0]            v_req_vld,
  input  logic [REQ_CHANNEL_NUM*ADDR_WIDTH-1:0] v_req_addr,
  input  logic [REQ_CHANNEL_NUM*2-1:0]          v_req_mode,
  input  logic [REQ_CHANNEL_NUM-1:0]            v_pass,
  output logic [REQ_CHANNEL_NUM-1:0]            v_req_kill,
  output logic                                  exc_vld,
  input  logic                                  exc_rdy,
  output logic [3:0]                            exc_cause,
  output logic [ADDR_WIDTH-1:0]                 exc_tval,
  input  logic                                  flush,
  output logic [3*CNT_WIDTH-1:0]                fault_cnt
);

  localparam int IDX_W = (REQ_CHANNEL_NUM > 1) ? $clog2(REQ_CHANNEL_NUM) : 1;

  pmp_fault_state_e            state_q, state_d;
  logic [3:0]                  excCause_q, excCause_d;
  logic [ADDR_WIDTH-1:0]       excTval_q, excTval_d;
  logic [REQ_CHANNEL_NUM-1:0]  chanFault;
  logic                        selHit;
  logic [IDX_W-1:0]            selIdx;
  logic [3:0]                  selCause;
  logic [ADDR_WIDTH-1:0]       selAddr;

  // A channel faults only when it carries a real access that the PMP rejected
  always_comb begin
    chanFault = '0;
    for (int i = 0; i < REQ_CHANNEL_NUM; i++) begin
      chanFault[i] = v_req_vld[i] & (v_req_mode[2*i +: 2] != PMP_MODE_NONE) & ~v_pass[i];
    end
  end

  pmp_fault_pick #(
    .REQ_CHANNEL_NUM (REQ_CHANNEL_NUM),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .IDX_W           (IDX_W)
  ) u_pick (
    .fault_i (chanFault),
    .addr_i  (v_req_addr),
    .mode_i  (v_req_mode),
    .hit_o   (selHit),
    .idx_o   (selIdx),
    .cause_o (selCause),
    .addr_o  (selAddr)
  );

  // Picker sanity: the chosen channel really faulted and no lower index did
  assert property (@(posedge clk) disable iff (!rst_n)
    selHit |-> (chanFault[selIdx] &&
                ((chanFault & ((REQ_CHANNEL_NUM'(1) << selIdx) - REQ_CHANNEL_NUM'(1))) == '0)));

  // Kill faulting accesses immediately, and everything once a fault is held
  assign v_req_kill = v_req_vld & (chanFault | {REQ_CHANNEL_NUM{state_q != IDLE}});

  // Next-state logic: capture in IDLE, offer in PEND, wait for flush after
  always_comb begin
    state_d    = state_q;
    excCause_d = excCause_q;
    excTval_d  = excTval_q;
    case (state_q)
      IDLE: begin
        if (selHit && !flush) begin
          excCause_d = selCause;
          excTval_d  = selAddr;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (flush) begin
          state_d = IDLE;
        end else if (exc_rdy) begin
          state_d = WAIT_FLUSH;
        end
      end
      WAIT_FLUSH: begin
        if (flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured exception registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      excCause_q <= '0;
      excTval_q  <= '0;
    end else begin
      state_q    <= state_d;
      excCause_q <= excCause_d;
      excTval_q  <= excTval_d;
    end
  end

  assign exc_vld   = (state_q == PEND);
  assign exc_cause = excCause_q;
  assign exc_tval  = excTval_q;

`ifdef PMP_FAULT_CNT_EN
  logic [2:0]           classHit;
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];

  // Flag which fault classes (0 fetch, 1 load, 2 store) occurred this cycle
  always_comb begin
    classHit = '0;
    for (int i = 0; i < REQ_CHANNEL_NUM; i++) begin
      if (chanFault[i]) begin
        case (v_req_mode[2*i +: 2])
          PMP_MODE_FETCH: classHit[0] = 1'b1;
          PMP_MODE_LOAD:  classHit[1] = 1'b1;
          PMP_MODE_STORE: classHit[2] = 1'b1;
          default:        ;
        endcase
      end
    end
  end

  // Saturating increment, at most one per class per cycle
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (classHit[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Counter registers; only reset clears them, flush does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign fault_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_pmp_fault_ctrl.sv
// Self-checking bench for pmp_fault_ctrl. Expected exceptions are queued
// when the faulting stimulus is driven and compared when exc_vld appears.
// Build with PMP_FAULT_CNT_EN to exercise the counters at CNT_WIDTH=2.
module tb_pmp_fault_ctrl;
  import pmp_fault_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
`ifdef PMP_FAULT_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  typedef struct packed {
    logic [3:0]    cause;
    logic [AW-1:0] tval;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    v_req_vld;
  logic [N*AW-1:0] v_req_addr;
  logic [N*2-1:0]  v_req_mode;
  logic [N-1:0]    v_pass;
  logic [N-1:0]    v_req_kill;
  logic            exc_vld;
  logic            exc_rdy;
  logic [3:0]      exc_cause;
  logic [AW-1:0]   exc_tval;
  logic            flush;
  logic [3*CW-1:0] fault_cnt;

  exp_t sbq[$];
  exp_t expItem;
  int   checks = 0;
  int   errors = 0;

  pmp_fault_ctrl #(
    .REQ_CHANNEL_NUM (N),
    .ADDR_WIDTH      (AW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .v_req_vld  (v_req_vld),
    .v_req_addr (v_req_addr),
    .v_req_mode (v_req_mode),
    .v_pass     (v_pass),
    .v_req_kill (v_req_kill),
    .exc_vld    (exc_vld),
    .exc_rdy    (exc_rdy),
    .exc_cause  (exc_cause),
    .exc_tval   (exc_tval),
    .flush      (flush),
    .fault_cnt  (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearInputs();
    v_req_vld  = '0;
    v_req_addr = '0;
    v_req_mode = '0;
    v_pass     = '1;
    exc_rdy    = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic setCh(input int ch, input logic [1:0] m, input logic [AW-1:0] a, input logic p);
    v_req_vld[ch]          = 1'b1;
    v_req_mode[ch*2 +: 2]  = m;
    v_req_addr[ch*AW +: AW] = a;
    v_pass[ch]             = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    @(negedge clk);
    checks++;
    if ({exc_vld, exc_cause, exc_tval} !== '0)
      begin errors++; $display("[TB] FAIL reset_exc: got %h expected 0", {exc_vld, exc_cause, exc_tval}); end
    checks++;
    if (fault_cnt !== '0)
      begin errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", fault_cnt); end
    setCh(0, PMP_MODE_LOAD, 32'h10, 1'b0);
    #1;
    checks++;
    if (v_req_kill !== 3'b001)
      begin errors++; $display("[TB] FAIL reset_kill: got %b expected 001", v_req_kill); end
    clearInputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    clearInputs();
    setCh(1, PMP_MODE_LOAD, 32'h8000_1000, 1'b0);
    sbq.push_back('{cause: EXC_LOAD_ACCESS_FAULT, tval: 32'h8000_1000});
    @(negedge clk);
    checks++;
    if (v_req_kill !== 3'b010)
      begin errors++; $display("[TB] FAIL single_kill: got %b expected 010", v_req_kill); end
    checks++;
    if (exc_vld !== 1'b0)
      begin errors++; $display("[TB] FAIL single_early_vld: got %b expected 0", exc_vld); end
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL single_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL single_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if ({exc_vld, exc_cause, exc_tval} !== {1'b1, EXC_LOAD_ACCESS_FAULT, 32'h8000_1000})
        begin errors++; $display("[TB] FAIL single_hold: got %h", {exc_vld, exc_cause, exc_tval}); end
    end
    exc_rdy = 1'b1;
    step();
    exc_rdy = 1'b0;
    setCh(2, PMP_MODE_LOAD, 32'h44, 1'b1);
    @(negedge clk);
    checks++;
    if ({exc_vld, v_req_kill} !== 4'b0100)
      begin errors++; $display("[TB] FAIL single_wait: got %b expected 0100", {exc_vld, v_req_kill}); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({exc_vld, v_req_kill} !== 4'b0000)
      begin errors++; $display("[TB] FAIL single_after_flush: got %b expected 0000", {exc_vld, v_req_kill}); end
    clearInputs();
  endtask

  task automatic test_simultaneous();
    clearInputs();
    setCh(0, PMP_MODE_FETCH, 32'h100, 1'b0);
    setCh(2, PMP_MODE_STORE, 32'h200, 1'b0);
    sbq.push_back('{cause: EXC_INSTR_ACCESS_FAULT, tval: 32'h100});
    @(negedge clk);
    checks++;
    if (v_req_kill !== 3'b101)
      begin errors++; $display("[TB] FAIL simul_kill: got %b expected 101", v_req_kill); end
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL simul_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL simul_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL simul_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    exc_rdy = 1'b1;
    step();
    exc_rdy = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (exc_vld !== 1'b0)
        begin errors++; $display("[TB] FAIL simul_dropped: got %b expected 0", exc_vld); end
    end
  endtask

  task automatic test_pend_hold();
    clearInputs();
    setCh(0, PMP_MODE_LOAD, 32'h40, 1'b0);
    sbq.push_back('{cause: EXC_LOAD_ACCESS_FAULT, tval: 32'h40});
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL hold_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL hold_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL hold_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      setCh(0, PMP_MODE_FETCH, 32'h1000 + AW'(k), 1'b0);
      @(negedge clk);
      checks++;
      if ({exc_vld, exc_cause, exc_tval, v_req_kill} !== {1'b1, EXC_LOAD_ACCESS_FAULT, 32'h40, 3'b001})
        begin errors++; $display("[TB] FAIL hold_stable: got %h", {exc_vld, exc_cause, exc_tval, v_req_kill}); end
    end
    step();
    clearInputs();
    exc_rdy = 1'b1;
    step();
    exc_rdy = 1'b0;
    for (int c = 0; c < N; c++) setCh(c, PMP_MODE_LOAD, 32'h80, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({exc_vld, v_req_kill} !== 4'b0111)
        begin errors++; $display("[TB] FAIL hold_killall: got %b expected 0111", {exc_vld, v_req_kill}); end
      step();
    end
    flush = 1'b1;
    step();
    clearInputs();
  endtask

  task automatic test_flush_priority();
    clearInputs();
    setCh(2, PMP_MODE_STORE, 32'h300, 1'b0);
    sbq.push_back('{cause: EXC_STORE_ACCESS_FAULT, tval: 32'h300});
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL prio_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL prio_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL prio_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    flush   = 1'b1;
    exc_rdy = 1'b1;
    step();
    clearInputs();
    setCh(1, PMP_MODE_FETCH, 32'h2000, 1'b0);
    sbq.push_back('{cause: EXC_INSTR_ACCESS_FAULT, tval: 32'h2000});
    @(negedge clk);
    checks++;
    if ({exc_vld, v_req_kill} !== 4'b0010)
      begin errors++; $display("[TB] FAIL prio_idle: got %b expected 0010", {exc_vld, v_req_kill}); end
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL prio_recap_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL prio_recap_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL prio_recap_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    exc_rdy = 1'b1;
    step();
    exc_rdy = 1'b0;
    flush = 1'b1;
    step();
    clearInputs();
  endtask

  task automatic test_flush_in_idle();
    clearInputs();
    flush = 1'b1;
    setCh(0, PMP_MODE_LOAD, 32'h500, 1'b0);
    @(negedge clk);
    checks++;
    if (v_req_kill !== 3'b001)
      begin errors++; $display("[TB] FAIL idleflush_kill: got %b expected 001", v_req_kill); end
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b0)
      begin errors++; $display("[TB] FAIL idleflush_vld: got %b expected 0", exc_vld); end
  endtask

  task automatic test_mode_none();
    clearInputs();
    setCh(0, PMP_MODE_NONE, 32'h600, 1'b0);
    setCh(2, PMP_MODE_NONE, 32'h604, 1'b0);
    @(negedge clk);
    checks++;
    if (v_req_kill !== 3'b000)
      begin errors++; $display("[TB] FAIL none_kill: got %b expected 000", v_req_kill); end
    step();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b0)
      begin errors++; $display("[TB] FAIL none_vld: got %b expected 0", exc_vld); end
    clearInputs();
  endtask

  task automatic test_reset_mid_pend();
    clearInputs();
    setCh(1, PMP_MODE_STORE, 32'h700, 1'b0);
    sbq.push_back('{cause: EXC_STORE_ACCESS_FAULT, tval: 32'h700});
    step();
    clearInputs();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL rstpend_vld: got %b expected 1", exc_vld); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL rstpend_sb: exception with empty scoreboard"); end
    else begin
      expItem = sbq.pop_front();
      if ({exc_cause, exc_tval} !== expItem)
        begin errors++; $display("[TB] FAIL rstpend_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
    end
    #2 rst_n = 1'b0;
    setCh(0, PMP_MODE_LOAD, 32'h20, 1'b1);
    #1;
    checks++;
    if ({exc_vld, exc_cause, exc_tval, v_req_kill, fault_cnt} !== '0)
      begin errors++; $display("[TB] FAIL rstpend_async: got %h expected 0", {exc_vld, exc_cause, exc_tval, v_req_kill}); end
    clearInputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (exc_vld !== 1'b0)
      begin errors++; $display("[TB] FAIL rstpend_after: got %b expected 0", exc_vld); end
  endtask

  task automatic test_counters();
    logic [3*CW-1:0] expCnt;
    int              storeModel;
    clearInputs();
    storeModel = 0;
    for (int k = 1; k <= 4; k++) begin
      setCh(2, PMP_MODE_STORE, 32'h900 + AW'(k), 1'b0);
      if (k == 1) sbq.push_back('{cause: EXC_STORE_ACCESS_FAULT, tval: 32'h901});
      step();
      if (storeModel < (1 << CW) - 1) storeModel++;
`ifdef PMP_FAULT_CNT_EN
      expCnt = {CW'(storeModel), CW'(0), CW'(0)};
`else
      expCnt = '0;
`endif
      @(negedge clk);
      checks++;
      if (fault_cnt !== expCnt)
        begin errors++; $display("[TB] FAIL cnt_store_%0d: got %h expected %h", k, fault_cnt, expCnt); end
      if (k == 1) begin
        checks++;
        if (exc_vld !== 1'b1) begin errors++; $display("[TB] FAIL cnt_vld: got %b expected 1", exc_vld); end
        else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL cnt_sb: exception with empty scoreboard"); end
        else begin
          expItem = sbq.pop_front();
          if ({exc_cause, exc_tval} !== expItem)
            begin errors++; $display("[TB] FAIL cnt_exc: got %h expected %h", {exc_cause, exc_tval}, expItem); end
        end
      end
    end
    clearInputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (fault_cnt !== expCnt)
      begin errors++; $display("[TB] FAIL cnt_after_flush: got %h expected %h", fault_cnt, expCnt); end
  endtask

  initial begin
    $display("[TB] starting pmp_fault_ctrl bench");
    test_reset();
    test_single_load();
    test_simultaneous();
    test_pend_hold();
    test_flush_priority();
    test_flush_in_idle();
    test_mode_none();
    test_reset_mid_pend();
    test_counters();
    checks++;
    if (sbq.size() != 0)
      begin errors++; $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
